mux_arb_4: RTL and testbench
============================

MUX_ARB_4 -- requirements
Module: mux_arb_4

Interface
REQ-001 SHALL have parameter: WIDTH, 4, data width per channel and output.
REQ-002 SHALL have port: clk  input  1  single clock, all state on posedge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: in_valid  input  4  per-channel request, bit i = channel i.
REQ-005 SHALL have port: in_ready  output  4  per-channel accept, at most one bit set.
REQ-006 SHALL have ports: d0, d1, d2, d3  input  WIDTH each  channel data.
REQ-007 SHALL have port: out_valid  output  1  output register holds a word.
REQ-008 SHALL have port: out_ready  input  1  downstream accepts the word.
REQ-009 SHALL have port: out_data  output  WIDTH  registered selected data.
REQ-010 SHALL have port: out_sel  output  2  registered index of the channel that produced out_data.

Function
REQ-011 SHALL keep a one-entry output register with two states: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-012 SHALL compute load = ~out_valid | out_ready; a grant occurs only when load=1 and in_valid!=0.
REQ-013 SHALL assert in_ready[i] combinationally only for the granted channel i; in_ready=0 whenever load=0 or in_valid=0.
REQ-014 SHALL have a transfer on channel i when in_valid[i] & in_ready[i]; out_data=di and out_sel=i appear on the next cycle (latency 1).
REQ-015 SHALL have these transitions: EMPTY->FULL on grant; FULL->FULL on out_ready with grant; FULL->EMPTY on out_ready without grant; FULL holds on ~out_ready.
REQ-016 SHALL hold out_data/out_sel stable while out_valid=1 and out_ready=0.
REQ-017 SHALL accept a new word in the same cycle that the old word drains (out_valid & out_ready & grant), giving 1 word/cycle throughput.
REQ-018 SHALL search for a grant starting from priority pointer ptr, wrapping 3->0; after granting i, ptr SHALL become (i+1) mod 4.
REQ-019 SHALL leave ptr unchanged in cycles without a grant.
REQ-020 SHALL NOT drop or duplicate a word: each transfer produces exactly one out_valid&out_ready beat.
REQ-021 SHALL ignore in_valid/d* of channels not granted; no input is stored except via grant.

Reset
REQ-022 SHALL, on rst=1 at posedge, set out_valid=0, out_data=0, out_sel=0, ptr=0 (channel 0 highest priority).
REQ-023 SHALL hold in_ready=0 during any cycle with rst=1.
REQ-024 SHALL discard a word held in the output register when reset occurs mid-operation; no grant is taken in the reset cycle.

Configuration
REQ-025 SHALL use macro MUX_ARB_4_RR_EN: when defined, arbitration is round-robin per REQ-018/019.
REQ-026 SHALL, without MUX_ARB_4_RR_EN, use fixed priority (channel 0 highest, 3 lowest) with ptr absent; all other behaviour is identical.

Structure
REQ-027 SHALL place in shared package mux_arb_pkg: N_CH=4 constant, typedef sel_t (logic [1:0]), typedef req_t (logic [3:0]).
REQ-028 SHALL use one sub-module rr_pick_4: combinational, inputs req_t req and sel_t ptr, outputs one-hot grant and sel_t index, built from &, |, ~ only.
REQ-029 SHALL drive out_data from the data/select path only; no latches; all state resets per REQ-022.

Verification
REQ-030 SHALL cover: reset, then in_valid=4'b0001, d0=4'hA, out_ready=1 -> next cycle out_valid=1, out_data=A, out_sel=0.
REQ-031 SHALL cover: RR enabled, in_valid=4'b1111 held, out_ready=1, d0..d3=1,2,3,4 -> out_sel sequence 0,1,2,3,0, one word per cycle.
REQ-032 SHALL cover: FULL with out_ready=0 for 3 cycles, in_valid=4'b0010 -> in_ready=0, out_data/out_sel stable; out_ready=1 -> same-cycle grant of channel 1.
REQ-033 SHALL cover: RR disabled, in_valid=4'b1010 held, out_ready=1 -> out_sel=1 every cycle, channel 3 starves.
REQ-034 SHALL cover: rst pulsed while out_valid=1 and in_valid=4'b0100 -> next cycle out_valid=0, out_sel=0, in_ready=0 during reset; after release first grant is channel 2.
REQ-035 SHALL cover: scoreboard over 1000 random in_valid/out_ready cycles -> every transfer appears exactly once at output, in order, with correct out_sel.

Source files
------------

// File: rtl/mux_arb_pkg.sv
// Shared types and constants for the 4-channel arbitrating mux.
// first_one() returns the lowest set bit of a request vector as a one-hot.
package mux_arb_pkg;

    localparam int unsigned N_CH = 4;

    typedef logic [1:0]      sel_t;
    typedef logic [N_CH-1:0] req_t;

    typedef enum logic {
        StEmpty,
        StFull
    } state_t;

    function automatic req_t first_one(input req_t r);
        req_t g;
        g[0] = r[0];
        g[1] = r[1] & ~r[0];
        g[2] = r[2] & ~r[1] & ~r[0];
        g[3] = r[3] & ~r[2] & ~r[1] & ~r[0];
        return g;
    endfunction

endpackage

// File: rtl/rr_pick_4.sv
// Combinational 4-way picker: grants the first requester at or after ptr, wrapping 3->0.
// Returns the grant as a one-hot vector plus its binary index.
module rr_pick_4
    import mux_arb_pkg::*;
(
    input  req_t req,
    input  sel_t ptr,
    output req_t grant,
    output sel_t index
);

    req_t w_mask;
    req_t w_hi;
    req_t w_hi_grant;
    req_t w_lo_grant;
    logic w_hi_any;

    // w_mask[i] is set when channel i sits at or above the pointer.
    assign w_mask[0] = ~ptr[1] & ~ptr[0];
    assign w_mask[1] = ~ptr[1];
    assign w_mask[2] = ~ptr[1] | ~ptr[0];
    assign w_mask[3] = 1'b1;

    assign w_hi       = req & w_mask;
    assign w_hi_any   = |w_hi;
    assign w_hi_grant = first_one(w_hi);
    assign w_lo_grant = first_one(req);

    assign grant    = w_hi_grant | (w_lo_grant & {N_CH{~w_hi_any}});
    assign index[0] = grant[1] | grant[3];
    assign index[1] = grant[2] | grant[3];

endmodule

// File: rtl/mux_arb_4.sv
// 4-channel arbitrating mux with a one-entry registered output stage.
// Define MUX_ARB_4_RR_EN for round-robin arbitration; otherwise fixed priority (ch0 highest).
module mux_arb_4
    import mux_arb_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       in_valid,
    output logic [3:0]       in_ready,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic [WIDTH-1:0] d3,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       out_sel
);

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_data;
    sel_t             r_sel;
    logic [WIDTH-1:0] w_data_sel;
    req_t             w_grant;
    sel_t             w_idx;
    sel_t             w_ptr;
    logic             w_load;
    logic             w_take;

`ifdef MUX_ARB_4_RR_EN
    sel_t r_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (w_take) begin
            r_ptr <= w_idx + 2'd1;
        end
    end

    assign w_ptr = r_ptr;
`else
    assign w_ptr = '0;
`endif

    rr_pick_4 u_pick (
        .req   (in_valid),
        .ptr   (w_ptr),
        .grant (w_grant),
        .index (w_idx)
    );

    // Reset blocks the grant so nothing is accepted while the stage is being cleared.
    assign w_load   = (r_state == StEmpty) | out_ready;
    assign w_take   = w_load & ~rst & (|in_valid);
    assign in_ready = w_take ? w_grant : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StEmpty;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StEmpty: if (w_take) w_state_next = StFull;
            StFull:  if (out_ready & ~w_take) w_state_next = StEmpty;
            default: w_state_next = StEmpty;
        endcase
    end

    always_comb begin
        out_valid = (r_state == StFull);
    end

    always_comb begin
        w_data_sel = d0;
        unique case (w_idx)
            2'd0: w_data_sel = d0;
            2'd1: w_data_sel = d1;
            2'd2: w_data_sel = d2;
            2'd3: w_data_sel = d3;
            default: w_data_sel = d0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data <= '0;
            r_sel  <= '0;
        end else if (w_take) begin
            r_data <= w_data_sel;
            r_sel  <= w_idx;
        end
    end

    assign out_data = r_data;
    assign out_sel  = r_sel;

endmodule

// File: tb/tb_mux_arb_4.sv
// Self-checking bench for mux_arb_4: directed scenarios plus a randomized scoreboard run
// against a behavioural model of the arbiter and output stage.
module tb_mux_arb_4;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] in_valid;
    logic [3:0] in_ready;
    logic [3:0] d0, d1, d2, d3;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_data;
    logic [1:0] out_sel;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model of the output register and arbitration pointer.
    bit         m_valid = 1'b0;
    logic [3:0] m_data  = '0;
    int         m_sel   = 0;
    int         m_ptr   = 0;

    typedef struct {
        logic [3:0] data;
        int         sel;
    } beat_t;

    beat_t sb_q[$];

    mux_arb_4 #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .d0        (d0),
        .d1        (d1),
        .d2        (d2),
        .d3        (d3),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sel   (out_sel)
    );

    always #5 clk = ~clk;

    function automatic int pick(input logic [3:0] req, input int ptr);
        for (int k = 0; k < 4; k++) begin
            int j;
            j = (ptr + k) % 4;
            if (req[j]) return j;
        end
        return -1;
    endfunction

    function automatic int model_grant();
        int p;
`ifdef MUX_ARB_4_RR_EN
        p = m_ptr;
`else
        p = 0;
`endif
        if (rst || !(!m_valid || out_ready)) return -1;
        return pick(in_valid, p);
    endfunction

    function automatic logic [3:0] model_ready();
        logic [3:0] r;
        int g;
        r = '0;
        g = model_grant();
        if (g >= 0) r[g] = 1'b1;
        return r;
    endfunction

    function automatic logic [3:0] chan_data(input int i);
        case (i)
            0: return d0;
            1: return d1;
            2: return d2;
            default: return d3;
        endcase
    endfunction

    // Advance one clock: model decides from pre-edge inputs, returns at the next negedge.
    task automatic tick();
        int g;
        logic [3:0] dg;
        g  = model_grant();
        dg = (g >= 0) ? chan_data(g) : 4'd0;
        @(posedge clk);
        if (rst) begin
            m_valid = 1'b0; m_data = '0; m_sel = 0; m_ptr = 0;
        end else if (g >= 0) begin
            m_valid = 1'b1; m_data = dg; m_sel = g; m_ptr = (g + 1) % 4;
        end else if (out_ready) begin
            m_valid = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = '0; out_ready = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
        d0 = 4'h1; d1 = 4'h2; d2 = 4'h3; d3 = 4'h4;
        tick();
        #1;
        n_checks++;
        if (in_ready !== 4'b0000) begin
            n_fail++; $display("FAIL reset_in_ready: got %b expected 0000", in_ready);
        end
        tick();
        rst = 1'b0; in_valid = '0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid);
        end
        n_checks++;
        if (out_data !== 4'h0 || out_sel !== 2'd0) begin
            n_fail++; $display("FAIL reset_out_regs: got data %h sel %0d expected 0/0", out_data, out_sel);
        end
    endtask

    task automatic test_single();
        do_reset();
        in_valid = 4'b0001; d0 = 4'hA; out_ready = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 4'b0001) begin
            n_fail++; $display("FAIL single_in_ready: got %b expected 0001", in_ready);
        end
        tick();
        in_valid = '0;
        #1;
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 4'hA || out_sel !== 2'd0) begin
            n_fail++; $display("FAIL single_out: got v%b d%h s%0d expected v1 dA s0", out_valid, out_data, out_sel);
        end
        tick();
        #1;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL single_drain: got out_valid %b expected 0", out_valid);
        end
    endtask

`ifdef MUX_ARB_4_RR_EN
    task automatic test_rr_sweep();
        do_reset();
        in_valid = 4'b1111; out_ready = 1'b1;
        d0 = 4'd1; d1 = 4'd2; d2 = 4'd3; d3 = 4'd4;
        for (int k = 0; k < 5; k++) begin
            logic [3:0] er;
            er = '0; er[k % 4] = 1'b1;
            #1;
            n_checks++;
            if (in_ready !== er) begin
                n_fail++; $display("FAIL rr_in_ready[%0d]: got %b expected %b", k, in_ready, er);
            end
            tick();
            #1;
            n_checks++;
            if (out_valid !== 1'b1 || out_sel !== 2'(k % 4) || out_data !== 4'(k % 4 + 1)) begin
                n_fail++; $display("FAIL rr_out[%0d]: got v%b s%0d d%0d expected v1 s%0d d%0d",
                                   k, out_valid, out_sel, out_data, k % 4, k % 4 + 1);
            end
        end
    endtask
`else
    task automatic test_fixed_starve();
        do_reset();
        in_valid = 4'b1010; out_ready = 1'b1; d1 = 4'h6; d3 = 4'hC;
        for (int k = 0; k < 5; k++) begin
            #1;
            n_checks++;
            if (in_ready !== 4'b0010) begin
                n_fail++; $display("FAIL fixed_in_ready[%0d]: got %b expected 0010", k, in_ready);
            end
            tick();
            #1;
            n_checks++;
            if (out_valid !== 1'b1 || out_sel !== 2'd1 || out_data !== 4'h6) begin
                n_fail++; $display("FAIL fixed_out[%0d]: got v%b s%0d d%h expected v1 s1 d6",
                                   k, out_valid, out_sel, out_data);
            end
        end
    endtask
`endif

    task automatic test_backpressure();
        do_reset();
        in_valid = 4'b0001; d0 = 4'h5; out_ready = 1'b0;
        tick();
        in_valid = 4'b0010; d1 = 4'h7;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_checks++;
            if (in_ready !== 4'b0000 || out_valid !== 1'b1 || out_data !== 4'h5 || out_sel !== 2'd0) begin
                n_fail++; $display("FAIL bp_hold[%0d]: got r%b v%b d%h s%0d expected r0000 v1 d5 s0",
                                   k, in_ready, out_valid, out_data, out_sel);
            end
            tick();
        end
        out_ready = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 4'b0010) begin
            n_fail++; $display("FAIL bp_release_ready: got %b expected 0010", in_ready);
        end
        tick();
        in_valid = '0;
        #1;
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 4'h7 || out_sel !== 2'd1) begin
            n_fail++; $display("FAIL bp_release_out: got v%b d%h s%0d expected v1 d7 s1", out_valid, out_data, out_sel);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        in_valid = 4'b0100; d2 = 4'h9; out_ready = 1'b0;
        tick();
        rst = 1'b1; out_ready = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 4'b0000) begin
            n_fail++; $display("FAIL rstmid_in_ready: got %b expected 0000", in_ready);
        end
        tick();
        rst = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || out_sel !== 2'd0) begin
            n_fail++; $display("FAIL rstmid_cleared: got v%b s%0d expected v0 s0", out_valid, out_sel);
        end
        n_checks++;
        if (in_ready !== 4'b0100) begin
            n_fail++; $display("FAIL rstmid_regrant: got %b expected 0100", in_ready);
        end
        tick();
        in_valid = '0;
        #1;
        n_checks++;
        if (out_valid !== 1'b1 || out_sel !== 2'd2 || out_data !== 4'h9) begin
            n_fail++; $display("FAIL rstmid_out: got v%b s%0d d%h expected v1 s2 d9", out_valid, out_sel, out_data);
        end
        tick();
    endtask

    task automatic test_random();
        int n_beats;
        n_beats = 0;
        do_reset();
        sb_q.delete();
        for (int c = 0; c < 1000; c++) begin
            in_valid  = 4'($urandom_range(0, 15));
            out_ready = ($urandom_range(0, 3) != 0);
            d0 = 4'($urandom); d1 = 4'($urandom); d2 = 4'($urandom); d3 = 4'($urandom);
            #1;
            n_checks++;
            if (in_ready !== model_ready()) begin
                n_fail++; $display("FAIL rand_in_ready[%0d]: got %b expected %b", c, in_ready, model_ready());
            end
            n_checks++;
            if (out_valid !== m_valid || (m_valid && (out_data !== m_data || out_sel !== 2'(m_sel)))) begin
                n_fail++; $display("FAIL rand_out[%0d]: got v%b d%h s%0d expected v%b d%h s%0d",
                                   c, out_valid, out_data, out_sel, m_valid, m_data, m_sel);
            end
            if (out_valid && out_ready) begin
                n_checks++;
                n_beats++;
                if (sb_q.size() == 0) begin
                    n_fail++; $display("FAIL rand_sb_extra[%0d]: got beat d%h s%0d expected none", c, out_data, out_sel);
                end else begin
                    beat_t b;
                    b = sb_q.pop_front();
                    if (out_data !== b.data || out_sel !== 2'(b.sel)) begin
                        n_fail++; $display("FAIL rand_sb[%0d]: got d%h s%0d expected d%h s%0d",
                                           c, out_data, out_sel, b.data, b.sel);
                    end
                end
            end
            for (int i = 0; i < 4; i++) begin
                if (in_valid[i] && in_ready[i]) sb_q.push_back('{data: chan_data(i), sel: i});
            end
            tick();
        end
        in_valid = '0; out_ready = 1'b1;
        #1;
        if (out_valid) begin
            beat_t b;
            if (sb_q.size() != 0) begin
                b = sb_q.pop_front();
                n_checks++;
                if (out_data !== b.data || out_sel !== 2'(b.sel)) begin
                    n_fail++; $display("FAIL rand_drain: got d%h s%0d expected d%h s%0d", out_data, out_sel, b.data, b.sel);
                end
            end
        end
        tick();
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++; $display("FAIL rand_sb_lost: got %0d words outstanding expected 0", sb_q.size());
        end
        n_checks++;
        if (n_beats < 100) begin
            n_fail++; $display("FAIL rand_throughput: got %0d beats expected at least 100", n_beats);
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = '0; out_ready = 1'b0;
        d0 = '0; d1 = '0; d2 = '0; d3 = '0;
        @(negedge clk);
        test_reset();
        test_single();
`ifdef MUX_ARB_4_RR_EN
        test_rr_sweep();
`else
        test_fixed_starve();
`endif
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
